// File: rtl/cardinal_router.sv
// Five-port mesh router: dimension-ordered (X first) routing, two VCs per input
// selected by a free-running polarity bit, round-robin output arbitration.
module cardinal_router #(
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          up_si,
    input  logic          down_si,
    input  logic          left_si,
    input  logic          right_si,
    input  logic          NIC_si,
    input  logic [DW-1:0] up_di,
    input  logic [DW-1:0] down_di,
    input  logic [DW-1:0] left_di,
    input  logic [DW-1:0] right_di,
    input  logic [DW-1:0] NIC_di,
    output logic          up_ri,
    output logic          down_ri,
    output logic          left_ri,
    output logic          right_ri,
    output logic          NIC_ri,
    output logic          up_so,
    output logic          down_so,
    output logic          left_so,
    output logic          right_so,
    output logic          NIC_so,
    output logic [DW-1:0] up_do,
    output logic [DW-1:0] down_do,
    output logic [DW-1:0] left_do,
    output logic [DW-1:0] right_do,
    output logic [DW-1:0] NIC_do,
    input  logic          up_ro,
    input  logic          down_ro,
    input  logic          left_ro,
    input  logic          right_ro,
    input  logic          NIC_ro,
    output logic          polarity_to_NIC
);
    localparam int NP = 5;
    localparam logic [2:0] P_UP = 3'd0, P_DOWN = 3'd1, P_LEFT = 3'd2, P_RIGHT = 3'd3, P_NIC = 3'd4;

    // Handshake: a flit moves on a rising edge where valid (si/so) and ready
    // (ri/ro) are both high; valid holds with stable data until that edge.
    logic          polarity;
    logic [NP-1:0] si, ri, so, ro;
    logic [DW-1:0] di [NP];
    logic [1:0]    buf_v [NP];
    logic [DW-1:0] buf_d [NP][2];
    logic [NP-1:0] cand_v, cand_legal, cand_free;
    logic [2:0]    cand_dest [NP];
    logic [DW-1:0] cand_flit [NP];
    logic [NP-1:0] ob_v;
    logic [DW-1:0] ob_d [NP];
    logic [1:0]    rr_ptr [NP];
    logic [NP-1:0] gnt_v;
    logic [1:0]    gnt_s [NP];
    logic [DW-1:0] gnt_flit [NP];

    assign si = {NIC_si, right_si, left_si, down_si, up_si};
    assign ro = {NIC_ro, right_ro, left_ro, down_ro, up_ro};
    assign di[0] = up_di;
    assign di[1] = down_di;
    assign di[2] = left_di;
    assign di[3] = right_di;
    assign di[4] = NIC_di;
    assign {NIC_ri, right_ri, left_ri, down_ri, up_ri} = ri;
    assign {NIC_so, right_so, left_so, down_so, up_so} = so;
    assign up_do    = ob_d[0];
    assign down_do  = ob_d[1];
    assign left_do  = ob_d[2];
    assign right_do = ob_d[3];
    assign NIC_do   = ob_d[4];
    assign polarity_to_NIC = polarity;
    assign so = ob_v;

    function automatic logic [2:0] route(input logic [DW-1:0] f);
        if (f[55:52] != 4'd0)      route = f[62] ? P_LEFT : P_RIGHT;
        else if (f[51:48] != 4'd0) route = f[61] ? P_DOWN : P_UP;
        else                       route = P_NIC;
    endfunction

    // Output o listens to every input except itself, in ascending port order.
    function automatic logic [2:0] src_of(input logic [2:0] o, input logic [1:0] s);
        src_of = ({1'b0, s} < o) ? {1'b0, s} : {1'b0, s} + 3'd1;
    endfunction

    function automatic logic [DW-1:0] hop_step(input logic [DW-1:0] f, input logic [2:0] dest);
        logic [DW-1:0] g;
        g = f;
        if (dest == P_LEFT || dest == P_RIGHT)   g[55:52] = f[55:52] - 4'd1;
        else if (dest == P_UP || dest == P_DOWN) g[51:48] = f[51:48] - 4'd1;
        return g;
    endfunction

    always_comb begin
        for (int i = 0; i < NP; i++) begin
            ri[i]         = ~|buf_v[i];
            cand_v[i]     = buf_v[i][polarity];
            cand_flit[i]  = buf_d[i][polarity];
            cand_dest[i]  = route(buf_d[i][polarity]);
            cand_legal[i] = (cand_dest[i] != 3'(i));
        end
    end

    always_comb begin
        logic [3:0] req;
        logic [1:0] idx;
        logic [2:0] src;
        req = '0;
        idx = '0;
        src = '0;
        for (int o = 0; o < NP; o++) begin
            gnt_v[o] = 1'b0;
            gnt_s[o] = 2'd0;
            for (int s = 0; s < 4; s++) begin
                src    = src_of(3'(o), 2'(s));
                req[s] = cand_v[src] & cand_legal[src] & (cand_dest[src] == 3'(o));
            end
            if (!ob_v[o] || ro[o]) begin
                for (int k = 0; k < 4; k++) begin
                    idx = rr_ptr[o] + 2'(k);
                    if (req[idx] && !gnt_v[o]) begin
                        gnt_v[o] = 1'b1;
                        gnt_s[o] = idx;
                    end
                end
            end
            src         = src_of(3'(o), gnt_s[o]);
            gnt_flit[o] = hop_step(cand_flit[src], 3'(o));
        end
    end

    // An illegal route frees its buffer the same way a granted move does.
    always_comb begin
        for (int i = 0; i < NP; i++) cand_free[i] = cand_v[i] & ~cand_legal[i];
        for (int o = 0; o < NP; o++) begin
            if (gnt_v[o]) cand_free[src_of(3'(o), gnt_s[o])] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            polarity <= 1'b0;
            ob_v     <= '0;
            for (int i = 0; i < NP; i++) begin
                buf_v[i]    <= 2'b00;
                buf_d[i][0] <= '0;
                buf_d[i][1] <= '0;
                ob_d[i]     <= '0;
                rr_ptr[i]   <= 2'd0;
            end
        end else begin
            polarity <= ~polarity;
            for (int i = 0; i < NP; i++) begin
                if (cand_free[i]) buf_v[i][polarity] <= 1'b0;
                if (si[i] && ri[i]) begin
                    buf_v[i][di[i][DW-1]] <= 1'b1;
                    buf_d[i][di[i][DW-1]] <= di[i];
                end
            end
            for (int o = 0; o < NP; o++) begin
                if (gnt_v[o]) begin
                    ob_v[o]   <= 1'b1;
                    ob_d[o]   <= gnt_flit[o];
                    rr_ptr[o] <= gnt_s[o] + 2'd1;
                end else if (ob_v[o] && ro[o]) begin
                    ob_v[o] <= 1'b0;
                    ob_d[o] <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_cardinal_router.sv
// Directed bench for cardinal_router: a routing model feeds per-output expected
// queues checked every cycle, plus literal checks on latency, order and backpressure.
module tb_cardinal_router;
    localparam int UP = 0, DOWN = 1, LEFT = 2, RIGHT = 3, NICP = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  tb_si = '0;
    logic [4:0]  tb_ro = '1;
    logic [63:0] tb_di [5];
    logic [4:0]  mon_ri, mon_so;
    logic [63:0] mon_do [5];
    logic        polarity;

    logic [63:0] exp_q [5][$];
    logic [63:0] got_q [5][$];
    int          n_vec = 0;
    int          n_err = 0;
    bit          mon_en = 1'b0;
    logic        mpol = 1'b0;
    logic [4:0]  prev_hold = '0;
    logic [63:0] prev_do [5];

    always #5 clk = ~clk;

    cardinal_router dut (
        .clk(clk), .reset(reset),
        .up_si(tb_si[0]), .down_si(tb_si[1]), .left_si(tb_si[2]), .right_si(tb_si[3]), .NIC_si(tb_si[4]),
        .up_di(tb_di[0]), .down_di(tb_di[1]), .left_di(tb_di[2]), .right_di(tb_di[3]), .NIC_di(tb_di[4]),
        .up_ri(mon_ri[0]), .down_ri(mon_ri[1]), .left_ri(mon_ri[2]), .right_ri(mon_ri[3]), .NIC_ri(mon_ri[4]),
        .up_so(mon_so[0]), .down_so(mon_so[1]), .left_so(mon_so[2]), .right_so(mon_so[3]), .NIC_so(mon_so[4]),
        .up_do(mon_do[0]), .down_do(mon_do[1]), .left_do(mon_do[2]), .right_do(mon_do[3]), .NIC_do(mon_do[4]),
        .up_ro(tb_ro[0]), .down_ro(tb_ro[1]), .left_ro(tb_ro[2]), .right_ro(tb_ro[3]), .NIC_ro(tb_ro[4]),
        .polarity_to_NIC(polarity)
    );

    function automatic logic [63:0] mk(input logic vc, input logic xd, input logic yd,
                                       input logic [4:0] rsv, input logic [3:0] hx,
                                       input logic [3:0] hy, input logic [47:0] pl);
        return {vc, xd, yd, rsv, hx, hy, pl};
    endfunction

    function automatic int dest_of(input logic [63:0] f);
        if (f[55:52] != 4'd0) return f[62] ? LEFT : RIGHT;
        if (f[51:48] != 4'd0) return f[61] ? DOWN : UP;
        return NICP;
    endfunction

    function automatic logic [63:0] after_hop(input logic [63:0] f, input int d);
        logic [63:0] g;
        g = f;
        if (d == LEFT || d == RIGHT) g[55:52] = f[55:52] - 4'd1;
        if (d == UP || d == DOWN)    g[51:48] = f[51:48] - 4'd1;
        return g;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic bit busy();
        bit b;
        b = (mon_so != 5'b0) || (mon_ri != 5'b11111);
        for (int o = 0; o < 5; o++) if (exp_q[o].size() != 0) b = 1'b1;
        return b;
    endfunction

    // Compare process: sampled mid-cycle, so handshakes seen here occur on the next edge.
    always @(negedge clk) begin
        int hit;
        int d;
        #3;
        if (mon_en) begin
            chk("polarity", 64'(polarity), 64'(mpol));
            for (int o = 0; o < 5; o++) begin
                if (prev_hold[o]) begin
                    chk("hold_so", 64'(mon_so[o]), 64'd1);
                    chk("hold_do", mon_do[o], prev_do[o]);
                end
                if (!mon_so[o]) begin
                    chk("idle_do_zero", mon_do[o], 64'd0);
                end else if (tb_ro[o] && !reset) begin
                    hit = -1;
                    for (int j = 0; j < exp_q[o].size(); j++)
                        if (hit < 0 && exp_q[o][j] === mon_do[o]) hit = j;
                    chk("delivered_flit_expected", 64'(hit >= 0), 64'd1);
                    if (hit >= 0) exp_q[o].delete(hit);
                    got_q[o].push_back(mon_do[o]);
                end
                prev_hold[o] = mon_so[o] & ~tb_ro[o] & ~reset;
                prev_do[o]   = mon_do[o];
            end
            if (reset) begin
                for (int o = 0; o < 5; o++) exp_q[o].delete();
            end else begin
                for (int i = 0; i < 5; i++) begin
                    if (tb_si[i] && mon_ri[i]) begin
                        d = dest_of(tb_di[i]);
                        if (d != i) exp_q[d].push_back(after_hop(tb_di[i], d));
                    end
                end
            end
            mpol = reset ? 1'b0 : ~mpol;
        end
    end

    task automatic send(input int p, input logic [63:0] f);
        int n;
        n = 0;
        tb_si[p] = 1'b1;
        tb_di[p] = f;
        #3;
        while (!mon_ri[p] && n < 50) begin
            @(negedge clk);
            #3;
            n++;
        end
        chk("send_accept", 64'(n < 50), 64'd1);
        @(negedge clk);
        tb_si[p] = 1'b0;
        tb_di[p] = '0;
    endtask

    // Called right after send: the flit must show within two more edges.
    task automatic expect_out(input string name, input int o, input logic [63:0] f);
        int  k;
        bit  seen;
        k = 0;
        seen = 1'b0;
        #3;
        while (k <= 2 && !seen) begin
            if (mon_so[o]) seen = 1'b1;
            else begin
                @(negedge clk);
                #3;
                k++;
            end
        end
        chk({name, "_latency"}, 64'(seen), 64'd1);
        if (seen) chk(name, mon_do[o], f);
        @(negedge clk);
    endtask

    task automatic wait_idle(input int maxc);
        int n;
        n = 0;
        #3;
        while (busy() && n < maxc) begin
            @(negedge clk);
            #3;
            n++;
        end
        chk("drain_timeout", 64'(n < maxc), 64'd1);
        @(negedge clk);
    endtask

    initial begin
        logic [63:0] fa, fb;
        for (int i = 0; i < 5; i++) tb_di[i] = '0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        mon_en = 1'b1;
        #3;
        chk("reset_so", 64'(mon_so), 64'd0);
        chk("reset_ri", 64'(mon_ri), 64'h1f);
        chk("reset_up_do", mon_do[UP], 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #3;
        chk("pol_first", 64'(polarity), 64'd0);
        @(negedge clk);
        #3;
        chk("pol_toggle", 64'(polarity), 64'd1);
        @(negedge clk);

        send(DOWN, mk(1, 0, 0, 5'h00, 4'd0, 4'd2, 48'h111));
        expect_out("down_to_up", UP, mk(1, 0, 0, 5'h00, 4'd0, 4'd1, 48'h111));
        send(UP, mk(1, 0, 1, 5'h0a, 4'd0, 4'd2, 48'h222));
        expect_out("up_to_down", DOWN, mk(1, 0, 1, 5'h0a, 4'd0, 4'd1, 48'h222));
        send(LEFT, mk(0, 0, 0, 5'h00, 4'd3, 4'd1, 48'h333));
        expect_out("left_to_right", RIGHT, mk(0, 0, 0, 5'h00, 4'd2, 4'd1, 48'h333));
        send(RIGHT, mk(1, 1, 0, 5'h00, 4'd2, 4'd0, 48'h444));
        expect_out("right_to_left", LEFT, mk(1, 1, 0, 5'h00, 4'd1, 4'd0, 48'h444));
        send(NICP, mk(0, 0, 0, 5'h00, 4'd2, 4'd2, 48'h555));
        expect_out("nic_to_right", RIGHT, mk(0, 0, 0, 5'h00, 4'd1, 4'd2, 48'h555));
        fa = mk(0, 1, 1, 5'h15, 4'd0, 4'd0, 48'hDEAD_BEEF_CAFE);
        send(DOWN, fa);
        expect_out("down_to_nic", NICP, fa);

        // U-turn and NIC->NIC are dropped; their buffers must free up.
        send(UP, mk(1, 0, 0, 5'h00, 4'd0, 4'd1, 48'h666));
        repeat (2) @(negedge clk);
        #3;
        chk("uturn_freed", 64'(mon_ri[UP]), 64'd1);
        @(negedge clk);
        send(NICP, mk(0, 0, 0, 5'h00, 4'd0, 4'd0, 48'h777));
        repeat (2) @(negedge clk);
        #3;
        chk("nic_nic_freed", 64'(mon_ri[NICP]), 64'd1);
        @(negedge clk);
        wait_idle(20);

        got_q[UP].delete();
        tb_ro[UP] = 1'b0;
        send(DOWN, mk(0, 0, 0, 5'h00, 4'd0, 4'd2, 48'hA0));
        repeat (4) @(negedge clk);
        #3;
        chk("bp_up_so", 64'(mon_so[UP]), 64'd1);
        chk("bp_up_do", mon_do[UP], mk(0, 0, 0, 5'h00, 4'd0, 4'd1, 48'hA0));
        @(negedge clk);
        send(DOWN, mk(1, 0, 0, 5'h00, 4'd0, 4'd3, 48'hB0));
        repeat (3) @(negedge clk);
        #3;
        chk("bp_down_ri", 64'(mon_ri[DOWN]), 64'd0);
        chk("bp_up_do_stable", mon_do[UP], mk(0, 0, 0, 5'h00, 4'd0, 4'd1, 48'hA0));
        @(negedge clk);
        tb_ro[UP] = 1'b1;
        wait_idle(20);
        chk("bp_count", 64'(got_q[UP].size()), 64'd2);
        if (got_q[UP].size() == 2) begin
            chk("bp_first", got_q[UP][0], mk(0, 0, 0, 5'h00, 4'd0, 4'd1, 48'hA0));
            chk("bp_second", got_q[UP][1], mk(1, 0, 0, 5'h00, 4'd0, 4'd2, 48'hB0));
        end

        // Up's pointer sits one past down, so service runs left, right, NIC, down.
        got_q[UP].delete();
        tb_si = 5'b11110;
        tb_di[DOWN]  = mk(0, 0, 0, 5'h00, 4'd0, 4'd1, 48'h4);
        tb_di[LEFT]  = mk(0, 0, 0, 5'h00, 4'd0, 4'd1, 48'h1);
        tb_di[RIGHT] = mk(0, 0, 0, 5'h00, 4'd0, 4'd1, 48'h2);
        tb_di[NICP]  = mk(0, 0, 0, 5'h00, 4'd0, 4'd1, 48'h3);
        #3;
        chk("cont_all_ready", 64'(mon_ri), 64'h1f);
        @(negedge clk);
        tb_si = '0;
        for (int i = 0; i < 5; i++) tb_di[i] = '0;
        wait_idle(40);
        chk("cont_count", 64'(got_q[UP].size()), 64'd4);
        if (got_q[UP].size() == 4) begin
            fb = got_q[UP][0]; chk("cont_order0", 64'(fb[47:0]), 64'h1);
            fb = got_q[UP][1]; chk("cont_order1", 64'(fb[47:0]), 64'h2);
            fb = got_q[UP][2]; chk("cont_order2", 64'(fb[47:0]), 64'h3);
            fb = got_q[UP][3]; chk("cont_order3", 64'(fb[47:0]), 64'h4);
        end

        tb_ro[UP] = 1'b0;
        send(DOWN, mk(0, 0, 0, 5'h00, 4'd0, 4'd1, 48'hC0));
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        tb_ro[UP] = 1'b1;
        #3;
        chk("midreset_so", 64'(mon_so), 64'd0);
        chk("midreset_ri", 64'(mon_ri), 64'h1f);
        @(negedge clk);
        repeat (4) @(negedge clk);

        // Reset restores priority to source 0 (down) on the up output.
        got_q[UP].delete();
        tb_si = 5'b00110;
        tb_di[DOWN] = mk(1, 0, 0, 5'h00, 4'd0, 4'd1, 48'h5);
        tb_di[LEFT] = mk(1, 0, 0, 5'h00, 4'd0, 4'd1, 48'h6);
        @(negedge clk);
        tb_si = '0;
        for (int i = 0; i < 5; i++) tb_di[i] = '0;
        wait_idle(20);
        chk("rrreset_count", 64'(got_q[UP].size()), 64'd2);
        if (got_q[UP].size() == 2) begin
            fb = got_q[UP][0]; chk("rrreset_first", 64'(fb[47:0]), 64'h5);
            fb = got_q[UP][1]; chk("rrreset_second", 64'(fb[47:0]), 64'h6);
        end

        for (int o = 0; o < 5; o++) chk("leftover_expected", 64'(exp_q[o].size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
